fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. Owns the PC and issues single-outstanding requests to a variable-latency instruction memory. Holds each returned word in a one-entry buffer and presents it, or a zero bubble, to IF/ID. Applies branch redirects from ID and drives the IF/ID flush.

---
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to instruction
// memory and holds one returned word for the IF/ID register, applying ID branch redirects.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        instr_valid_o,
   output logic        flush_o
);

   typedef enum logic [1:0] {StIdle, StWait, StFull, StDiscard} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] target;

   assign target = {branch_target_i[31:2], 2'b00};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      unique case (state_q)
         StIdle: begin
            if (branch_i) begin
               pc_d = target;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (branch_i) begin
               // A response landing in the redirect cycle is stale; drop it and refetch.
               pc_d    = target;
               state_d = imem_rvalid_i ? StIdle : StDiscard;
            end else if (imem_rvalid_i) begin
               buf_d   = imem_rdata_i;
               state_d = StFull;
            end
         end
         StFull: begin
            if (branch_i) begin
               pc_d    = target;
               state_d = StIdle;
            end else if (!stall_i) begin
               pc_d    = pc_q + 32'(PC_STEP);
               state_d = StIdle;
            end
         end
         StDiscard: begin
            if (branch_i) begin
               pc_d = target;
            end
            if (imem_rvalid_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign imem_req_o    = (state_q == StIdle) & ~branch_i & ~rst_i;
   assign imem_addr_o   = pc_q;
   assign instr_valid_o = (state_q == StFull);
   assign instr_o       = instr_valid_o ? buf_q : '0;
   assign pc_o          = instr_valid_o ? pc_q : '0;
   assign flush_o       = branch_i;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: acts as a variable-latency instruction memory, keeps a transaction-level
// model of the fetch stream and checks DUT outputs against a scoreboard every cycle.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned PC_STEP  = 4;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch;
   logic [31:0] target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        rvalid;
   logic [31:0] rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic        flush;

   fetch_unit #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .stall_i         (stall),
      .branch_i        (branch),
      .branch_target_i (target),
      .imem_req_o      (imem_req),
      .imem_addr_o     (imem_addr),
      .imem_rvalid_i   (rvalid),
      .imem_rdata_i    (rdata),
      .instr_o         (instr),
      .pc_o            (pc),
      .instr_valid_o   (instr_valid),
      .flush_o         (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   // Scoreboard of {pc, instr} words the fetch stage is expected to present.
   logic [63:0] sb[$];

   // Transaction-level model state.
   logic [31:0] model_pc  = RESET_PC;
   logic        pending   = 1'b0;
   logic        live      = 1'b0;
   logic        orphan    = 1'b0;
   logic        buf_m     = 1'b0;
   logic [31:0] req_addr  = '0;
   int          cnt       = 0;
   int          lat       = 1;
   logic        exp_req   = 1'b0;
   logic        exp_valid = 1'b0;
   logic [31:0] exp_addr  = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h0010_0093;
      if (a == 32'h0000_0008) return 32'hAAAA_AAAA;
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // One clock cycle of stimulus; memory responses and the model advance here.
   task automatic step(input logic r, input logic st, input logic br, input logic [31:0] tgt,
                       input logic spur);
      logic deliver;
      @(posedge clk);
      #1;
      rst    = r;
      stall  = st;
      branch = br & ~r;
      target = tgt;
      rvalid = 1'b0;
      rdata  = $urandom;
      if (r) begin
         exp_req   = 1'b0;
         exp_valid = 1'b0;
         if (pending) orphan = 1'b1;
         pending  = 1'b0;
         live     = 1'b0;
         buf_m    = 1'b0;
         model_pc = RESET_PC;
      end else begin
         exp_valid = buf_m;
         exp_req   = !pending && !buf_m && !br;
         exp_addr  = model_pc;
         deliver   = pending && (cnt == 0);
         if (deliver) begin
            rvalid = 1'b1;
            rdata  = mem_word(req_addr);
         end else if (orphan) begin
            rvalid = 1'b1;
            rdata  = 32'hBAD0_0001;
         end else if (spur && !pending) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
         end
         orphan = 1'b0;
         if (pending && !deliver) cnt--;
         if (br) begin
            model_pc = tgt & ~32'h3;
            live     = 1'b0;
            buf_m    = 1'b0;
         end else if (buf_m && !st) begin
            model_pc = model_pc + PC_STEP;
            buf_m    = 1'b0;
         end
         if (deliver) begin
            pending = 1'b0;
            if (live) begin
               sb.push_back({req_addr, mem_word(req_addr)});
               buf_m = 1'b1;
            end
         end
         if (exp_req) begin
            pending  = 1'b1;
            live     = 1'b1;
            req_addr = model_pc;
            cnt      = lat - 1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   // Monitor: compares at the falling edge, away from state updates.
   always @(negedge clk) begin
      chk("flush", 32'(flush), 32'(branch));
      chk("req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("req_addr", imem_addr, exp_addr);
      chk("valid", 32'(instr_valid), 32'(exp_valid));
      if (instr_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL sb_empty at %0t: got valid instr %h expected none", $time, instr);
         end else begin
            chk("instr", instr, sb[0][31:0]);
            chk("pc", pc, sb[0][63:32]);
            if (!branch && !rst && !stall) void'(sb.pop_front());
         end
      end else begin
         chk("bubble_instr", instr, 32'h0);
         chk("bubble_pc", pc, 32'h0);
      end
      if (branch || rst) sb.delete();
   end

   initial begin
      rst    = 1'b1;
      stall  = 1'b0;
      branch = 1'b0;
      target = '0;
      rvalid = 1'b0;
      rdata  = '0;
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // Latency-1 fetches from reset, then a 3-cycle stall on the word at 0x8.
      lat = 1;
      idle(8);
      repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      idle(4);
      // Redirect to 0x40 while the latency-4 fetch of 0x10 is outstanding.
      lat = 4;
      idle(1);
      lat = 1;
      step(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
      idle(5);
      // Branch wins over stall; unaligned target is forced to 0x100.
      step(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
      idle(2);
      // Spurious response while holding a word, then PC wrap from 0xFFFF_FFFC.
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      idle(3);
      // Reset during an outstanding fetch; the late response lands after release.
      lat = 3;
      idle(1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      idle(6);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         lat = int'($urandom_range(1, 4));
         t   = $urandom;
         if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), t, ($urandom_range(0, 5) == 0));
      end
      idle(4);
      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
